// File: rtl/lut_function_eval.sv
// Clocked N-input boolean function evaluator backed by a run-time reloadable truth table.
// The table is loaded serially (MSB first) into a shadow register and committed atomically.
module lut_function_eval #(
  parameter int                   N          = 3,
  parameter logic [(1<<N)-1:0]    DEFAULT_TT = 8'h31,
  parameter int                   CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vec,
  output logic             out_valid,
  output logic             y,
  input  logic             clr_count,
  output logic [CNT_W-1:0] hit_count
);

  localparam int             TT_W     = 1 << N;
  localparam logic [N-1:0]   LAST_IDX = N'(TT_W - 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t            r_state;
  logic [TT_W-1:0]   r_table;
  logic [TT_W-1:0]   r_shadow;
  logic [N-1:0]      r_idx;
  logic              r_cfg_done;
  logic              r_out_valid;
  logic              r_y;
  logic [CNT_W-1:0]  r_hit_count;

  logic              w_accept;
  logic [N-1:0]      w_pos;
  logic [TT_W-1:0]   w_shadow_next;

  assign in_ready  = (r_state == ST_RUN);
  assign w_accept  = in_valid & in_ready;
  assign cfg_done  = r_cfg_done;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign hit_count = r_hit_count;

  // Shadow image including the bit arriving this cycle, so the final bit commits with the rest.
  always_comb begin
    w_pos         = LAST_IDX - r_idx;
    w_shadow_next = r_shadow;
    w_shadow_next[w_pos] = cfg_bit;
  end

  // Load state machine: RUN accepts requests; LOAD shifts bits into the shadow table.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_table    <= DEFAULT_TT;
      r_shadow   <= {TT_W{1'b0}};
      r_idx      <= {N{1'b0}};
      r_cfg_done <= 1'b0;
    end else begin
      r_cfg_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (cfg_start) begin
            r_state  <= ST_LOAD;
            r_idx    <= {N{1'b0}};
            r_shadow <= {TT_W{1'b0}};
          end else begin
            r_state  <= ST_RUN;
          end
        end
        ST_LOAD: begin
          if (cfg_start) begin
            r_idx    <= {N{1'b0}};
            r_shadow <= {TT_W{1'b0}};
          end else if (cfg_valid) begin
            r_shadow <= w_shadow_next;
            if (r_idx == LAST_IDX) begin
              r_table    <= w_shadow_next;
              r_cfg_done <= 1'b1;
              r_state    <= ST_RUN;
              r_idx      <= {N{1'b0}};
            end else begin
              r_idx      <= r_idx + N'(1);
            end
          end else begin
            r_idx    <= r_idx;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // Evaluation pipeline: one-cycle latency, y holds its value when nothing is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_y         <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_y <= r_table[in_vec];
      end else begin
        r_y <= r_y;
      end
    end
  end

  // Saturating tally of produced true results; clear wins over a coincident hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_count <= {CNT_W{1'b0}};
    end else if (clr_count) begin
      r_hit_count <= {CNT_W{1'b0}};
    end else if (r_out_valid && r_y && (r_hit_count != {CNT_W{1'b1}})) begin
      r_hit_count <= r_hit_count + CNT_W'(1);
    end else begin
      r_hit_count <= r_hit_count;
    end
  end

endmodule

// File: tb/tb_lut_function_eval.sv
// Self-checking bench for lut_function_eval with a queue-based behavioural reference model.
module tb_lut_function_eval;
  localparam int N     = 3;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             cfg_start, cfg_valid, cfg_bit;
  logic             cfg_done;
  logic             in_valid, in_ready;
  logic [N-1:0]     in_vec;
  logic             out_valid, y;
  logic             clr_count;
  logic [CNT_W-1:0] hit_count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0] m_table;
  bit         m_load;
  bit         m_q[$];
  bit         m_ov, m_y, m_done;
  int         m_cnt;

  lut_function_eval #(.N(N), .DEFAULT_TT(8'h31), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_done(cfg_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .y(y),
    .clr_count(clr_count), .hit_count(hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    reset = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    in_valid = 1'b0; in_vec = '0; clr_count = 1'b0;
  endtask

  // advance the model by one clock using the current inputs, then advance the DUT
  task automatic tick();
    int nc;
    logic [7:0] t;
    if (reset) begin
      m_table = 8'h31; m_load = 0; m_q.delete(); m_ov = 0; m_y = 0; m_done = 0; m_cnt = 0;
    end else begin
      if (clr_count) nc = 0;
      else if (m_ov && m_y) nc = (m_cnt < SAT) ? m_cnt + 1 : SAT;
      else nc = m_cnt;
      if (in_valid && !m_load) begin
        m_ov = 1; m_y = m_table[in_vec];
      end else begin
        m_ov = 0;
      end
      m_done = 0;
      if (cfg_start) begin
        m_load = 1; m_q.delete();
      end else if (m_load && cfg_valid) begin
        m_q.push_back(cfg_bit);
        if (m_q.size() == 8) begin
          t = '0;
          for (int i = 0; i < 8; i++) t[7-i] = m_q[i];
          m_table = t; m_done = 1; m_load = 0; m_q.delete();
        end
      end
      m_cnt = nc;
    end
    @(posedge clk); #1;
  endtask

  // stimulus only: start a load and send n_bits of tt MSB first with random idle gaps
  task automatic do_load(input logic [7:0] tt, input int n_bits);
    idle_inputs();
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    for (int i = 0; i < n_bits; i++) begin
      cfg_valid = 1'b1; cfg_bit = tt[7-i]; tick();
      cfg_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_tests++;
    if ({out_valid, y, cfg_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs got ov/y/done=%b%b%b exp 000", out_valid, y, cfg_done);
    end
    n_tests++;
    if (hit_count !== '0) begin
      n_fail++; $display("FAIL reset_hit_count got %0d exp 0", hit_count);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_default_sweep();
    logic [7:0] exp_tt = 8'h31;
    for (int v = 0; v < 8; v++) begin
      in_valid = 1'b1; in_vec = v[N-1:0]; tick();
      n_tests++;
      if (out_valid !== 1'b1 || y !== exp_tt[v]) begin
        n_fail++; $display("FAIL default_sweep v=%0d got ov=%b y=%b exp ov=1 y=%b", v, out_valid, y, exp_tt[v]);
      end
    end
    in_valid = 1'b0; tick();
    n_tests++;
    if (out_valid !== 1'b0 || y !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold got ov=%b y=%b exp ov=0 y=0", out_valid, y);
    end
    n_tests++;
    if (hit_count !== 4'd3) begin
      n_fail++; $display("FAIL default_hits got %0d exp 3", hit_count);
    end
  endtask

  task automatic test_load_with_idle();
    logic [7:0] tt = 8'h96;
    idle_inputs();
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1; cfg_bit = tt[7-i];
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL load_in_ready bit=%0d got %b exp 0", i, in_ready);
      end
      tick();
      cfg_valid = 1'b0;
      if (i < 7) begin
        n_tests++;
        if (cfg_done !== 1'b0) begin
          n_fail++; $display("FAIL early_cfg_done bit=%0d got %b exp 0", i, cfg_done);
        end
      end
      if (i == 2 || i == 5) tick();
    end
    n_tests++;
    if (cfg_done !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL load_commit got done=%b ready=%b exp 1 1", cfg_done, in_ready);
    end
    for (int v = 0; v < 8; v++) begin
      in_valid = 1'b1; in_vec = v[N-1:0]; tick();
      if (v == 0) begin
        n_tests++;
        if (cfg_done !== 1'b0) begin
          n_fail++; $display("FAIL done_pulse_width got %b exp 0", cfg_done);
        end
      end
      n_tests++;
      if (out_valid !== 1'b1 || y !== tt[v]) begin
        n_fail++; $display("FAIL sweep_96 v=%0d got ov=%b y=%b exp 1 %b", v, out_valid, y, tt[v]);
      end
    end
    idle_inputs(); tick();
  endtask

  task automatic test_reset_during_load();
    logic [7:0] exp_tt = 8'h31;
    int dones = 0;
    do_load(8'h96, 8); tick();
    do_load(8'h0F, 4);
    reset = 1'b1; tick(); reset = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_load_ready got %b exp 1", in_ready);
    end
    for (int v = 0; v < 8; v++) begin
      in_valid = 1'b1; in_vec = v[N-1:0]; tick();
      if (cfg_done) dones++;
      n_tests++;
      if (y !== exp_tt[v]) begin
        n_fail++; $display("FAIL rst_load_sweep v=%0d got %b exp %b", v, y, exp_tt[v]);
      end
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL rst_load_no_done got %0d pulses exp 0", dones);
    end
    idle_inputs(); tick();
  endtask

  task automatic test_restart_load();
    int dones = 0;
    do_load(8'h5A, 3);
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    if (cfg_done) dones++;
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b1; tick();
      if (cfg_done) dones++;
    end
    idle_inputs(); tick(); if (cfg_done) dones++;
    tick(); if (cfg_done) dones++;
    n_tests++;
    if (dones !== 1) begin
      n_fail++; $display("FAIL restart_done_count got %0d exp 1", dones);
    end
    for (int v = 0; v < 8; v++) begin
      in_valid = 1'b1; in_vec = v[N-1:0]; tick();
      n_tests++;
      if (y !== 1'b1) begin
        n_fail++; $display("FAIL restart_sweep v=%0d got %b exp 1", v, y);
      end
    end
    idle_inputs(); tick();
  endtask

  task automatic test_saturate_clear();
    idle_inputs();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_vec = '0; tick();
    end
    in_valid = 1'b0; tick(); tick();
    n_tests++;
    if (hit_count !== 4'd15) begin
      n_fail++; $display("FAIL saturate got %0d exp 15", hit_count);
    end
    in_valid = 1'b1; in_vec = '0; tick();
    in_valid = 1'b0; clr_count = 1'b1; tick(); clr_count = 1'b0;
    n_tests++;
    if (hit_count !== 4'd0) begin
      n_fail++; $display("FAIL clear_on_hit got %0d exp 0", hit_count);
    end
    tick();
  endtask

  task automatic test_cfg_and_eval();
    idle_inputs();
    reset = 1'b1; tick(); reset = 1'b0;
    in_valid = 1'b1; in_vec = 3'd4; cfg_start = 1'b1; tick();
    idle_inputs();
    n_tests++;
    if (out_valid !== 1'b1 || y !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_eval got ov=%b y=%b exp 1 1", out_valid, y);
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_load got ready=%b exp 0", in_ready);
    end
    do_load(8'h31, 8); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      cfg_start = ($urandom_range(0, 19) == 0);
      cfg_valid = $urandom_range(0, 1);
      cfg_bit   = $urandom_range(0, 1);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_vec    = $urandom_range(0, 7);
      clr_count = ($urandom_range(0, 39) == 0);
      n_tests++;
      if (in_ready !== !m_load) begin
        n_fail++; $display("FAIL rand_ready cyc=%0d got %b exp %b", c, in_ready, !m_load);
      end
      tick();
      n_tests++;
      if (out_valid !== m_ov || cfg_done !== m_done || (m_ov && y !== m_y)) begin
        n_fail++; $display("FAIL rand_out cyc=%0d got ov=%b y=%b done=%b exp ov=%b y=%b done=%b",
                           c, out_valid, y, cfg_done, m_ov, m_y, m_done);
      end
      n_tests++;
      if (hit_count !== m_cnt[CNT_W-1:0]) begin
        n_fail++; $display("FAIL rand_count cyc=%0d got %0d exp %0d", c, hit_count, m_cnt);
      end
    end
    idle_inputs(); tick();
  endtask

  initial begin
    idle_inputs();
    m_table = 8'h31; m_load = 0; m_ov = 0; m_y = 0; m_done = 0; m_cnt = 0;
    test_reset();
    test_default_sweep();
    test_load_with_idle();
    test_reset_during_load();
    test_restart_load();
    test_saturate_clear();
    test_cfg_and_eval();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
